// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ valid/ready requesters.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters and a stall counter.
module alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*4-1:0]        req_aluop,
  input  logic [NREQ*WORD_W-1:0]   req_a,
  input  logic [NREQ*WORD_W-1:0]   req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [WORD_W-1:0]        rsp_o,
  output logic [2:0]               rsp_nzv,
  output logic [3:0]               alu_aluop,
  output logic [WORD_W-1:0]        alu_port_a,
  output logic [WORD_W-1:0]        alu_port_b,
  input  logic [WORD_W-1:0]        alu_port_o,
  input  logic                     alu_n,
  input  logic                     alu_z,
  input  logic                     alu_v,
  output logic                     busy,
  output logic [ID_W-1:0]          gnt_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]    stat_grants,
  output logic [CNT_W-1:0]         stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [ID_W:0]   NREQ_L   = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ-1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     gnt_id_r;
  logic [3:0]          op_r;
  logic [WORD_W-1:0]   a_r;
  logic [WORD_W-1:0]   b_r;
  logic [WORD_W-1:0]   res_r;
  logic [2:0]          nzv_r;
  logic [NREQ-1:0]     rsp_valid_r;
  logic                busy_r;

  logic [NREQ-1:0]     rot_s;
  logic [ID_W-1:0]     off_s;
  logic [ID_W:0]       wsum_s;
  logic [ID_W-1:0]     win_id_s;
  logic                win_valid_s;
  logic                accept_s;
  logic [3:0]          sel_op_s;
  logic [WORD_W-1:0]   sel_a_s;
  logic [WORD_W-1:0]   sel_b_s;

  // Winner search: rotate so rr_ptr sits at bit 0, lowest set bit is the offset from rr_ptr.
  always_comb begin
    rot_s = NREQ'({req_valid, req_valid} >> rr_ptr_r);
    off_s = {ID_W{1'b0}};
    for (int k = NREQ-1; k >= 0; k--) begin
      off_s = rot_s[k] ? ID_W'(k) : off_s;
    end
    wsum_s      = {1'b0, rr_ptr_r} + {1'b0, off_s};
    win_id_s    = (wsum_s >= NREQ_L) ? ID_W'(wsum_s - NREQ_L) : wsum_s[ID_W-1:0];
    win_valid_s = |req_valid;
    accept_s    = win_valid_s && (state_r == IDLE) && !RST;
  end

  // Operand mux selecting the winning requester's fields.
  always_comb begin
    sel_op_s = 4'h0;
    sel_a_s  = {WORD_W{1'b0}};
    sel_b_s  = {WORD_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sel_op_s = (win_id_s == ID_W'(k)) ? req_aluop[k*4 +: 4]        : sel_op_s;
      sel_a_s  = (win_id_s == ID_W'(k)) ? req_a[k*WORD_W +: WORD_W]  : sel_a_s;
      sel_b_s  = (win_id_s == ID_W'(k)) ? req_b[k*WORD_W +: WORD_W]  : sel_b_s;
    end
  end

  // Ready is combinational so a request can be taken in the cycle it is first seen.
  assign req_ready = accept_s ? (ONE_HOT0 << win_id_s) : {NREQ{1'b0}};

  // Control FSM; operands, result, response valid and busy are all registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      gnt_id_r    <= {ID_W{1'b0}};
      op_r        <= 4'h0;
      a_r         <= {WORD_W{1'b0}};
      b_r         <= {WORD_W{1'b0}};
      res_r       <= {WORD_W{1'b0}};
      nzv_r       <= 3'b000;
      rsp_valid_r <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= sel_op_s;
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            gnt_id_r <= win_id_s;
            busy_r   <= 1'b1;
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          res_r       <= alu_port_o;
          nzv_r       <= {alu_n, alu_z, alu_v};
          rr_ptr_r    <= (gnt_id_r == LAST_ID) ? {ID_W{1'b0}} : gnt_id_r + ID_W'(1);
          rsp_valid_r <= ONE_HOT0 << gnt_id_r;
          state_r     <= RESP;
        end
        RESP: begin
          if (|(rsp_valid_r & rsp_ready)) begin
            rsp_valid_r <= {NREQ{1'b0}};
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= {NREQ{1'b0}};
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_aluop  = op_r;
  assign alu_port_a = a_r;
  assign alu_port_b = b_r;
  assign rsp_o      = res_r;
  assign rsp_nzv    = nzv_r;
  assign rsp_valid  = rsp_valid_r;
  assign busy       = busy_r;
  assign gnt_id     = gnt_id_r;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREQ-1:0][CNT_W-1:0] grants_r;
  logic [CNT_W-1:0]           stall_r;

  // Saturating grant and stall counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grants_r <= {(NREQ*CNT_W){1'b0}};
      stall_r  <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (accept_s && (win_id_s == ID_W'(k)) && (grants_r[k] != CNT_MAX)) begin
          grants_r[k] <= grants_r[k] + CNT_W'(1);
        end
      end
      if ((|(req_valid & ~req_ready)) && (stall_r != CNT_MAX)) begin
        stall_r <= stall_r + CNT_W'(1);
      end
    end
  end

  assign stat_grants = grants_r;
  assign stat_stall  = stall_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed plan cases followed by randomized traffic,
// with a transaction-level reference model and a behavioural ALU stand-in.
module tb_alu_arbiter;
  localparam int NREQ  = 2;
  localparam int W     = 32;
  localparam int CNT_W = 16;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*4-1:0] req_aluop;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      rsp_o, alu_port_a, alu_port_b, alu_port_o;
  logic [2:0]        rsp_nzv;
  logic [3:0]        alu_aluop;
  logic              alu_n, alu_z, alu_v, busy;
  logic [0:0]        gnt_id;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] stat_grants;
  logic [CNT_W-1:0]      stat_stall;
`endif

  alu_arbiter #(.NREQ(NREQ), .WORD_W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o), .rsp_nzv(rsp_nzv),
    .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_port_o(alu_port_o), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .busy(busy), .gnt_id(gnt_id)
`ifdef ALU_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    case (alu_aluop)
      OP_ADD:  alu_port_o = alu_port_a + alu_port_b;
      OP_SUB:  alu_port_o = alu_port_a - alu_port_b;
      default: alu_port_o = alu_port_a ^ alu_port_b;
    endcase
    alu_n = alu_port_o[W-1];
    alu_z = (alu_port_o == '0);
    case (alu_aluop)
      OP_ADD:  alu_v = (alu_port_a[W-1] == alu_port_b[W-1]) && (alu_port_o[W-1] != alu_port_a[W-1]);
      OP_SUB:  alu_v = (alu_port_a[W-1] != alu_port_b[W-1]) && (alu_port_o[W-1] != alu_port_a[W-1]);
      default: alu_v = 1'b0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [31:0] o;
    logic [2:0]  nzv;
  } exp_t;

  exp_t sbq[$];
  exp_t rsp_log[$];
  int   grant_log[$];

  // Reference: wide signed arithmetic, overflow when the 32-bit result no longer equals it.
  function automatic exp_t ref_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r  = (op == OP_ADD) ? sa + sb : sa - sb;
    e.id  = id;
    e.o   = r[31:0];
    e.nzv = {e.o[31], (e.o == 32'd0), (r != longint'($signed(e.o)))};
    return e;
  endfunction

  bit  m_out;
  int  m_age, m_ptr, m_id, stall_m;
  int  grant_m[NREQ];

  // Monitor: predicts ready/valid per cycle, checks responses against the scoreboard head.
  initial begin
    logic [NREQ-1:0] exp_ready, exp_rsp, hs;
    int w, idx;
    exp_t e;
    m_out = 1'b0; m_age = 0; m_ptr = 0; m_id = 0; stall_m = 0;
    foreach (grant_m[i]) grant_m[i] = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id), 64'd0);
        chk("rst_rsp_o", 64'(rsp_o), 64'd0);
        sbq.delete();
        m_out = 1'b0; m_age = 0; m_ptr = 0; stall_m = 0;
        foreach (grant_m[i]) grant_m[i] = 0;
      end else begin
        exp_ready = '0;
        w = -1;
        if (!m_out) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && req_valid[idx]) w = idx;
          end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_out));
        if (m_out) chk("gnt_id", 64'(gnt_id), 64'(m_id));
        exp_rsp = '0;
        if (m_out && m_age >= 2) exp_rsp[m_id] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (rsp_valid != '0) begin
          chk("sb_size", 64'(sbq.size()), 64'd1);
          if (sbq.size() > 0) begin
            chk("rsp_o", 64'(rsp_o), 64'(sbq[0].o));
            chk("rsp_nzv", 64'(rsp_nzv), 64'(sbq[0].nzv));
          end
          if ((rsp_valid & rsp_ready) != '0) begin
            e.id = 0;
            for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) e.id = k;
            e.o = rsp_o;
            e.nzv = rsp_nzv;
            rsp_log.push_back(e);
          end
        end
        hs = req_valid & req_ready;
        if (hs != '0) begin
          idx = 0;
          for (int k = NREQ-1; k >= 0; k--) if (hs[k]) idx = k;
          grant_log.push_back(idx);
        end
        if ((req_valid & ~exp_ready) != '0) stall_m++;
        if (m_out) begin
          if (m_age >= 2 && rsp_ready[m_id]) begin
            void'(sbq.pop_front());
            m_out = 1'b0;
          end else begin
            m_age++;
          end
        end else if (w >= 0) begin
          sbq.push_back(ref_op(w, req_aluop[w*4 +: 4], req_a[w*W +: W], req_b[w*W +: W]));
          m_id = w; m_ptr = (w + 1) % NREQ; m_out = 1'b1; m_age = 1;
          grant_m[w]++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_aluop[i*4 +: 4] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One cycle: note handshakes away from the edge, then retire accepted requests.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge CLK);
    acc = req_valid & req_ready;
    @(posedge CLK);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((req_valid != '0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= 200), 64'd0);
  endtask

  task automatic chk_rsp(input string name, input int idx, input int id, input logic [31:0] o, input logic [2:0] nzv);
    chk({name, "_seen"}, 64'(rsp_log.size() > idx), 64'd1);
    if (rsp_log.size() > idx) begin
      chk({name, "_id"}, 64'(rsp_log[idx].id), 64'(id));
      chk({name, "_o"}, 64'(rsp_log[idx].o), 64'(o));
      chk({name, "_nzv"}, 64'(rsp_log[idx].nzv), 64'(nzv));
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, gbase, n;
    RST = 1'b1; req_valid = '0; req_aluop = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    rsp_ready = '1;

    // Single ADD: ready in the same cycle, response two edges later.
    base = rsp_log.size();
    set_req(0, OP_ADD, 32'd5, 32'd7);
    #1;
    chk("add_ready_same_cycle", 64'(req_ready), 64'd1);
    wait_idle("add");
    chk_rsp("add", base, 0, 32'd12, 3'b000);

    base = rsp_log.size();
    set_req(1, OP_SUB, 32'h3, 32'h3);
    wait_idle("zero");
    chk_rsp("zero", base, 1, 32'd0, 3'b010);

    base = rsp_log.size();
    set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h1);
    wait_idle("ovf");
    chk_rsp("ovf", base, 0, 32'h8000_0000, 3'b101);

    // Contention: both requesters valid continuously from reset.
    RST = 1'b1;
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_SUB, 32'd9, 32'd4);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    gbase = grant_log.size();
    base = rsp_log.size();
    n = 0;
    while (grant_log.size() < gbase + 8 && n < 200) begin
      step();
      n++;
      if (grant_log.size() < gbase + 8) begin
        set_req(0, OP_ADD, 32'd1, 32'd1);
        set_req(1, OP_SUB, 32'd9, 32'd4);
      end else begin
        req_valid = '0;
      end
    end
    chk("contention_timeout", 64'(n >= 200), 64'd0);
    wait_idle("contention");
    for (int j = 0; j < 8; j++) begin
      if (grant_log.size() > gbase + j) chk("grant_order", 64'(grant_log[gbase + j]), 64'(j % 2));
      chk_rsp("contention", base + j, j % 2, (j % 2) ? 32'd5 : 32'd2, 3'b000);
    end
`ifdef ALU_ARB_STATS_EN
    chk("stat_grants0", 64'(stat_grants[0 +: CNT_W]), 64'd4);
    chk("stat_grants1", 64'(stat_grants[CNT_W +: CNT_W]), 64'd4);
    chk("stat_stall", 64'(stat_stall), 64'(stall_m));
    RST = 1'b1;
    #1;
    chk("stat_grants_rst", 64'(stat_grants), 64'd0);
    chk("stat_stall_rst", 64'(stat_stall), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
`endif

    // Backpressure: response held with outputs stable, no new grants.
    base = rsp_log.size();
    rsp_ready = '0;
    set_req(0, OP_ADD, 32'd100, 32'd23);
    step();
    set_req(1, OP_SUB, 32'd50, 32'd8);
    repeat (10) step();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp_o", 64'(rsp_o), 64'd123);
    rsp_ready = '1;
    wait_idle("bp");
    chk_rsp("bp0", base, 0, 32'd123, 3'b000);
    chk_rsp("bp1", base + 1, 1, 32'd42, 3'b000);

    // Reset while in RESP: response discarded, round-robin restarts at requester 0.
    rsp_ready = '0;
    set_req(0, OP_ADD, 32'd2, 32'd2);
    n = 0;
    while (rsp_valid == '0 && n < 20) begin
      step();
      n++;
    end
    chk("resp_reach_timeout", 64'(n >= 20), 64'd0);
    set_req(1, OP_SUB, 32'd6, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rsp_o", 64'(rsp_o), 64'd0);
    chk("rst_mid_alu_a", 64'(alu_port_a), 64'd0);
    base = rsp_log.size();
    gbase = grant_log.size();
    repeat (2) @(posedge CLK);
    #1;
    set_req(0, OP_ADD, 32'd6, 32'd6);
    RST = 1'b0;
    rsp_ready = '1;
    wait_idle("after_rst");
    if (grant_log.size() > gbase) chk("first_grant_after_rst", 64'(grant_log[gbase]), 64'd0);
    chk("rsp_count_after_rst", 64'(rsp_log.size()), 64'(base + 2));
    chk_rsp("after_rst0", base, 0, 32'd12, 3'b000);
    chk_rsp("after_rst1", base + 1, 1, 32'd5, 3'b000);

    // Randomized traffic with random backpressure and occasional withdrawn requests.
    repeat (400) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, ($urandom_range(0, 1) == 1) ? OP_ADD : OP_SUB, rand_word(), rand_word());
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rsp_ready = '1;
    wait_idle("random_drain");
    chk("sb_empty_at_end", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between NREQ requesters. Each requester uses a valid/ready request channel and a valid/ready response channel.
- Selects requesters round-robin and registers the operands and the ALU result.
- Sits between the FPGA/debug front-ends or datapath stages and the single `alu` through `alu_if`.
- One transaction is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..4).
- WORD_W, 32, operand/result width; matches word_t.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  request valid, one bit per requester.
- req_ready  output  NREQ  request accepted, one-hot or zero.
- req_aluop  input  NREQ*4  per-requester aluop_t; requester i in bits [4i+3:4i].
- req_a  input  NREQ*WORD_W  per-requester port_a operand.
- req_b  input  NREQ*WORD_W  per-requester port_b operand.
- rsp_valid  output  NREQ  response valid, one-hot or zero.
- rsp_ready  input  NREQ  response accepted.
- rsp_o  output  WORD_W  result, shared by all requesters.
- rsp_nzv  output  3  flags {n,z,v}, shared.
- alu_aluop  output  4  drives aluif.aluop.
- alu_port_a  output  WORD_W  drives aluif.port_a.
- alu_port_b  output  WORD_W  drives aluif.port_b.
- alu_port_o  input  WORD_W  from aluif.port_o.
- alu_n, alu_z, alu_v  input  1 each  flags from aluif.
- busy  output  1  high when state != IDLE.
- gnt_id  output  $clog2(NREQ)  id of the requester currently owning the ALU.

Behaviour:
- Reset (asynchronous, RST=1), values held while RST=1:
  - state=IDLE, rr_ptr=0, gnt_id=0.
  - Operand registers (op, a, b) and result registers all 0.
  - All req_ready and rsp_valid outputs 0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g = first i at or after rr_ptr (mod NREQ) with req_valid[i]=1.
  - req_ready[g]=1 combinationally; all other req_ready bits 0.
  - On req_valid[g]&req_ready[g]: capture req_aluop/a/b of g into the operand registers, gnt_id<=g, go to EXEC.
  - No valid requests: stay in IDLE, all req_ready=0.
- EXEC:
  - alu_* outputs are always driven from the operand registers.
  - At the end of the cycle, capture alu_port_o and {alu_n,alu_z,alu_v} into the result registers.
  - rr_ptr <= (gnt_id+1) mod NREQ; go to RESP.
- RESP:
  - rsp_valid[gnt_id]=1; rsp_o and rsp_nzv come from the result registers and are stable.
  - On rsp_ready[gnt_id]=1, go to IDLE.
  - No new request is accepted in RESP: req_ready=0.
- Latency and throughput:
  - Request handshake at edge T gives rsp_valid high from cycle T+1 (visible after edge T+1); earliest response handshake at edge T+2.
  - Peak throughput: one op per 3 cycles.
  - Backpressure on rsp_ready stalls indefinitely with outputs held.
- Simultaneous requests: rr_ptr decides. Two requests at rr_ptr=0 → 0 is served, then 1.
  - Dropping req_valid before the handshake is legal: no grant, no state change.
- Requester contract: keep req_* stable while req_valid=1 and not accepted.
- Reset mid-operation: the in-flight transaction is discarded and no response is issued; rr_ptr returns to 0.
- No arithmetic in this block. Flags and results are taken verbatim from the ALU.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NREQ*CNT_W). Counter i increments on each accepted request from requester i.
  - Adds output stat_stall (CNT_W). Increments once per cycle in which any i has req_valid[i]=1 and req_ready[i]=0.
  - All counters saturate at all-ones and reset to 0.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan (bench connects the real `alu` through `alu_if`):
- Single ADD: req0 aluop=ALU_ADD(4'h2), a=5, b=7.
  - Required: req_ready[0] same cycle; rsp_valid[0] two edges later; rsp_o=12, nzv=3'b000.
- Zero flag: req1 SUB(4'h3), a=b=32'h3.
  - Required: rsp_valid[1] only; rsp_o=0, nzv=3'b010; rsp_valid[0] stays 0.
- Overflow: req0 ADD, a=32'h7FFFFFFF, b=1.
  - Required: rsp_o=32'h80000000, nzv=3'b101.
- Contention: req0 and req1 valid continuously from reset.
  - Required: grant order 0,1,0,1.
  - Each rsp_o matches its own operands, e.g. req0 a=1,b=1 ADD → 2; req1 a=9,b=4 SUB → 5.
- Backpressure and reset:
  - Hold rsp_ready[0]=0 for 10 cycles: rsp_valid and rsp_o stable, busy=1, req_ready=0.
  - Assert RST in RESP: all outputs 0 immediately, no response afterwards, next grant goes to requester 0.
- With ALU_ARB_STATS_EN: contention run with 4 grants each.
  - Required: stat_grants={4,4}; stat_stall counts every waiting cycle; stat_grants=0 after RST.
